// File: rtl/sync_event_pkg.sv
// Shared types and default widths for the synchronized event queue.
package sync_event_pkg;

   localparam int unsigned DEF_CNT_W  = 8;
   localparam int unsigned DEF_PEND_W = 4;

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      IDLE = 2'd1,
      HIGH = 2'd2
   } ev_state_t;

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter holding the number of queued events.
// A simultaneous inc and dec cancels, so saturation never drops an event then.
module sat_updown_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         sat_drop
);

   localparam logic [W-1:0] MAX = {W{1'b1}};

   logic at_max_c;
   logic at_zero_c;

   // Saturation flags and the drop indication for an unpaired increment at max.
   always_comb begin
      at_max_c  = (count == MAX);
      at_zero_c = (count == W'(0));
      sat_drop  = inc & ~dec & at_max_c;
   end

   // Pending count register.
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= W'(0);
      end else if (inc && !dec && !at_max_c) begin
         count <= count + W'(1);
      end else if (dec && !inc && !at_zero_c) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/sync_event_queue.sv
// Turns rising edges of an already-synchronized level into queued events
// with a valid/ready pop port, a wrapping total count and a sticky overflow.
module sync_event_queue
   import sync_event_pkg::*;
#(
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter int unsigned PEND_W = DEF_PEND_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sync_in,
   input  logic              ev_ready,
   input  logic              clr_ovf,
   output logic              ev_valid,
   output logic              ev_pulse,
   output logic [PEND_W-1:0] pending,
   output logic [CNT_W-1:0]  total,
   output logic              ovf
);

   ev_state_t state_q;
   ev_state_t state_d;
   logic      rise_c;
   logic      pop_c;
   logic      sat_drop;

   // State register; ARM after reset so a level already high is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARM;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and rise detection; only IDLE->HIGH is an event.
   always_comb begin
      state_d = state_q;
      rise_c  = 1'b0;
      pop_c   = ev_valid & ev_ready;
      case (state_q)
         ARM:  if (!sync_in) state_d = IDLE;
         IDLE: if (sync_in) begin
                  state_d = HIGH;
                  rise_c  = 1'b1;
               end
         HIGH: if (!sync_in) state_d = IDLE;
         default: state_d = ARM;
      endcase
   end

   // Pending queue depth with saturation.
   sat_updown_counter #(
      .W(PEND_W)
   ) u_pending (
      .clk      (clk),
      .clr      (rst),
      .inc      (rise_c),
      .dec      (pop_c),
      .count    (pending),
      .sat_drop (sat_drop)
   );

   // Event strobe, total counter and valid flag tracking the next pending value.
   always_ff @(posedge clk) begin
      if (rst) begin
         ev_pulse <= 1'b0;
         ev_valid <= 1'b0;
         total    <= CNT_W'(0);
      end else begin
         ev_pulse <= rise_c;
         if (rise_c) begin
            total <= total + CNT_W'(1);
         end
         if (rise_c) begin
            ev_valid <= 1'b1;
         end else if (pop_c) begin
            ev_valid <= (pending != PEND_W'(1));
         end
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (sat_drop) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sync_event_queue.sv
// Directed bench: stimulus pushes expected events, a monitor pops on ev_pulse.
module tb_sync_event_queue;

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned PEND_W = 4;

   typedef struct {
      int total;
      int pend;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              sync_in;
   logic              ev_ready;
   logic              clr_ovf;
   logic              ev_valid;
   logic              ev_pulse;
   logic [PEND_W-1:0] pending;
   logic [CNT_W-1:0]  total;
   logic              ovf;

   int   checks;
   int   failures;
   exp_t sb[$];

   sync_event_queue #(
      .CNT_W  (CNT_W),
      .PEND_W (PEND_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sync_in  (sync_in),
      .ev_ready (ev_ready),
      .clr_ovf  (clr_ovf),
      .ev_valid (ev_valid),
      .ev_pulse (ev_pulse),
      .pending  (pending),
      .total    (total),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int hi, input int lo);
      sync_in = 1'b1;
      step(hi);
      sync_in = 1'b0;
      step(lo);
   endtask

   task automatic expect_ev(input int t, input int p);
      exp_t e;
      e.total = t;
      e.pend  = p;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      sync_in = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   // Monitor: every strobe must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst && ev_pulse) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ev_pulse actual=1 expected=0 total=%0d", total);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ev_total", int'(total), e.total);
            chk("ev_pending", int'(pending), e.pend);
            chk("ev_valid_at_pulse", int'(ev_valid), 1);
         end
      end
   end

   // Bound total simulation time.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      sync_in  = 1'b1;
      ev_ready = 1'b0;
      clr_ovf  = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
      chk("rst_pulse", int'(ev_pulse), 0);
      chk("rst_valid", int'(ev_valid), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_total", int'(total), 0);
      chk("rst_ovf", int'(ovf), 0);

      // Level high out of reset is ignored; only the later pulse counts.
      step(5);
      sync_in = 1'b0;
      step(2);
      expect_ev(1, 1);
      pulse(3, 2);
      chk("t1_total", int'(total), 1);
      chk("t1_pending", int'(pending), 1);

      // Three pulses held, then drained.
      do_reset();
      expect_ev(1, 1);
      pulse(2, 2);
      expect_ev(2, 2);
      pulse(2, 2);
      expect_ev(3, 3);
      pulse(2, 2);
      chk("t2_pending", int'(pending), 3);
      chk("t2_total", int'(total), 3);
      chk("t2_valid", int'(ev_valid), 1);
      ev_ready = 1'b1;
      step(3);
      ev_ready = 1'b0;
      chk("t2_drained_pending", int'(pending), 0);
      chk("t2_drained_valid", int'(ev_valid), 0);
      ev_ready = 1'b1;
      step(2);
      ev_ready = 1'b0;
      chk("t2_ready_idle_pending", int'(pending), 0);

      // Saturation and overflow.
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         expect_ev(i, (i > 15) ? 15 : i);
         pulse(2, 2);
      end
      chk("t3_pending", int'(pending), 15);
      chk("t3_total", int'(total), 17);
      chk("t3_ovf", int'(ovf), 1);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("t3_ovf_cleared", int'(ovf), 0);
      chk("t3_pending_kept", int'(pending), 15);

      // Rise with pop at max: no change, no overflow.
      expect_ev(18, 15);
      sync_in  = 1'b1;
      ev_ready = 1'b1;
      step(1);
      ev_ready = 1'b0;
      step(1);
      sync_in = 1'b0;
      step(2);
      chk("t4_pending", int'(pending), 15);
      chk("t4_ovf", int'(ovf), 0);

      // Overflow set beats a simultaneous clear.
      expect_ev(19, 15);
      sync_in = 1'b1;
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      step(1);
      sync_in = 1'b0;
      step(2);
      chk("t4_ovf_set_wins", int'(ovf), 1);

      // Total wraps after 257 events with immediate pops.
      do_reset();
      ev_ready = 1'b1;
      for (int i = 1; i <= 257; i++) begin
         expect_ev(i % 256, 1);
         pulse(2, 2);
      end
      ev_ready = 1'b0;
      chk("t5_total", int'(total), 1);
      chk("t5_pending", int'(pending), 0);
      chk("t5_ovf", int'(ovf), 0);
      chk("t5_valid", int'(ev_valid), 0);

      // Reset mid-operation with the level held high.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         expect_ev(i, i);
         pulse(2, 2);
      end
      chk("t6_pending_before", int'(pending), 5);
      sync_in = 1'b1;
      step(1);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      chk("t6_pulse", int'(ev_pulse), 0);
      chk("t6_valid", int'(ev_valid), 0);
      chk("t6_pending", int'(pending), 0);
      chk("t6_total", int'(total), 0);
      chk("t6_ovf", int'(ovf), 0);
      step(4);
      chk("t6_total_held_high", int'(total), 0);
      sync_in = 1'b0;
      step(2);
      expect_ev(1, 1);
      pulse(2, 2);
      chk("t6_total_after", int'(total), 1);
      chk("t6_pending_after", int'(pending), 1);

      step(3);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
